// File: rtl/bkram_save_ctrl.sv
// -----------------------------------------------------------------------------
// bkram_save_ctrl
//
// Purpose:
//   Backup-RAM save/load controller. Moves SECTORS 512-byte sectors between
//   the core's backup RAM and a save-image slot through a sector handshake
//   (sd_rd/sd_wr raised, sd_ack rise then fall per sector). It also formats
//   the backup RAM by writing a header followed by zeros. It tracks whether
//   saving is permitted (bk_ena) and whether unsaved changes exist
//   (bk_pending).
//
// Ports:
//   clk_sys       in   sole clock
//   reset         in   asynchronous, active-high reset
//   downloading   in   cart download active
//   img_mounted   in   save-image mount pulse
//   img_readonly  in   mounted image is read-only
//   img_size_nz   in   mounted image has nonzero size
//   load_req      in   OSD load request (level, rising edge acts)
//   save_req      in   OSD save request (level, rising edge acts)
//   format_req    in   OSD format request (level, rising edge acts)
//   autosave_en   in   save automatically when the OSD opens with changes
//   osd_status    in   OSD is open
//   ram_wr        in   core backup-RAM write strobe
//   slot          in   save slot select
//   sd_lba        out  sector address (slot*SECTORS + sector)
//   sd_rd, sd_wr  out  sector read / write request strobes
//   sd_ack        in   sector handshake acknowledge
//   fmt_we        out  format write enable
//   fmt_addr      out  format write address (16-bit words)
//   fmt_data      out  format write data
//   bk_ena        out  save/load permitted
//   bk_busy       out  transfer or format in progress
//   bk_loading    out  load in progress (core held in reset)
//   bk_pending    out  backup RAM holds unsaved changes
// -----------------------------------------------------------------------------
module bkram_save_ctrl #(
   parameter int unsigned SECTORS   = 16,
   parameter int unsigned SLOT_W    = 2,
   parameter int unsigned HDR_WORDS = 4,
   parameter logic [63:0] HDR       = 64'h8010_8800_4D42_5548,
   localparam int unsigned FA_W     = $clog2(SECTORS * 256)
) (
   input  logic              clk_sys,
   input  logic              reset,

   input  logic              downloading,
   input  logic              img_mounted,
   input  logic              img_readonly,
   input  logic              img_size_nz,

   input  logic              load_req,
   input  logic              save_req,
   input  logic              format_req,
   input  logic              autosave_en,
   input  logic              osd_status,
   input  logic              ram_wr,

   input  logic [SLOT_W-1:0] slot,

   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,

   output logic              fmt_we,
   output logic [FA_W-1:0]   fmt_addr,
   output logic [15:0]       fmt_data,

   output logic              bk_ena,
   output logic              bk_busy,
   output logic              bk_loading,
   output logic              bk_pending
);

   // A single-sector slot still needs a 1-bit sector counter.
   localparam int unsigned SEC_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;

   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECTORS - 1);
   localparam logic [FA_W-1:0]  FA_LAST  = FA_W'(SECTORS * 256 - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_FMT  = 2'd3;

   logic [1:0]       state;
   logic [SEC_W-1:0] sector;

   // History registers for edge detection
   logic load_req_d;
   logic save_req_d;
   logic format_req_d;
   logic downloading_d;
   logic autosave_d;
   logic sd_ack_d;

   logic autosave_lvl;
   logic load_edge;
   logic save_edge;
   logic format_edge;
   logic dl_rise;
   logic dl_fall;
   logic autosave_edge;
   logic ack_rise;
   logic ack_fall;

   logic load_start;
   logic save_start;
   logic xfer_start;
   logic fmt_start;
   logic fmt_done;
   logic pending_set;

   // Header word k for address k < HDR_WORDS, zero elsewhere.
   function automatic logic [15:0] hdr_word(input logic [FA_W-1:0] a);
      logic [15:0] w;
      w = '0;
      for (int unsigned k = 0; k < HDR_WORDS; k++) begin
         if (a == FA_W'(k))
            w = HDR[16*k +: 16];
      end
      return w;
   endfunction

   assign autosave_lvl  = bk_pending & osd_status & autosave_en;

   assign load_edge     = load_req     & ~load_req_d;
   assign save_edge     = save_req     & ~save_req_d;
   assign format_edge   = format_req   & ~format_req_d;
   assign dl_rise       = downloading  & ~downloading_d;
   assign dl_fall       = ~downloading & downloading_d;
   assign autosave_edge = autosave_lvl & ~autosave_d;
   assign ack_rise      = sd_ack       & ~sd_ack_d;
   assign ack_fall      = ~sd_ack      & sd_ack_d;

   // Start decisions only exist in IDLE; edges seen elsewhere are consumed
   // by the history registers and therefore dropped. Load beats save, and
   // either transfer beats a simultaneous format request.
   always_comb begin
      load_start = 1'b0;
      save_start = 1'b0;
      fmt_start  = 1'b0;
      if (state == S_IDLE) begin
         load_start = bk_ena & (load_edge | (dl_fall & img_size_nz));
         save_start = bk_ena & (save_edge | autosave_edge) & ~load_start;
         fmt_start  = format_edge & ~load_start & ~save_start;
      end
   end

   assign xfer_start  = load_start | save_start;
   assign fmt_done    = (state == S_FMT) && (fmt_addr == FA_LAST);
   assign pending_set = (ram_wr & bk_ena & ~osd_status) | (fmt_done & bk_ena);

   // Edge history
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         load_req_d    <= 1'b0;
         save_req_d    <= 1'b0;
         format_req_d  <= 1'b0;
         downloading_d <= 1'b0;
         autosave_d    <= 1'b0;
         sd_ack_d      <= 1'b0;
      end else begin
         load_req_d    <= load_req;
         save_req_d    <= save_req;
         format_req_d  <= format_req;
         downloading_d <= downloading;
         autosave_d    <= autosave_lvl;
         sd_ack_d      <= sd_ack;
      end
   end

   // Save enable: a new download disables saving until a writable image is
   // mounted; a mount in the same cycle as the download edge keeps it set.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         bk_ena <= 1'b0;
      else if (downloading & img_mounted & ~img_readonly)
         bk_ena <= 1'b1;
      else if (dl_rise)
         bk_ena <= 1'b0;
   end

   // Unsaved-changes flag: a set in the same cycle as a transfer start wins.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         bk_pending <= 1'b0;
      else if (pending_set)
         bk_pending <= 1'b1;
      else if (xfer_start)
         bk_pending <= 1'b0;
   end

   // Transfer / format sequencer
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         sector     <= '0;
         sd_lba     <= '0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         fmt_we     <= 1'b0;
         fmt_addr   <= '0;
         fmt_data   <= '0;
         bk_busy    <= 1'b0;
         bk_loading <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer_start) begin
                  sector     <= '0;
                  sd_lba     <= 32'(slot) * 32'(SECTORS);
                  bk_busy    <= 1'b1;
                  bk_loading <= load_start;
                  sd_rd      <= load_start;
                  sd_wr      <= save_start;
                  state      <= S_REQ;
               end else if (fmt_start) begin
                  bk_busy  <= 1'b1;
                  fmt_we   <= 1'b1;
                  fmt_addr <= '0;
                  fmt_data <= hdr_word('0);
                  state    <= S_FMT;
               end
            end

            S_REQ: begin
               if (ack_rise) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  state <= S_XFER;
               end
            end

            S_XFER: begin
               if (ack_fall) begin
                  if (sector == SEC_LAST) begin
                     bk_busy    <= 1'b0;
                     bk_loading <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     // bk_loading still records the transfer direction.
                     sector <= sector + 1'b1;
                     sd_lba <= sd_lba + 32'd1;
                     sd_rd  <= bk_loading;
                     sd_wr  <= ~bk_loading;
                     state  <= S_REQ;
                  end
               end
            end

            S_FMT: begin
               if (fmt_addr == FA_LAST) begin
                  fmt_we   <= 1'b0;
                  fmt_addr <= '0;
                  fmt_data <= '0;
                  bk_busy  <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  // Data is registered alongside the address it belongs to.
                  fmt_addr <= fmt_addr + 1'b1;
                  fmt_data <= hdr_word(fmt_addr + 1'b1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bkram_save_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bkram_save_ctrl
//
// Directed self-checking bench for bkram_save_ctrl with default parameters
// (16 sectors per slot, 4 slots, 4096-word format).
// -----------------------------------------------------------------------------
module tb_bkram_save_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        downloading  = 1'b0;
   logic        img_mounted  = 1'b0;
   logic        img_readonly = 1'b0;
   logic        img_size_nz  = 1'b0;
   logic        load_req     = 1'b0;
   logic        save_req     = 1'b0;
   logic        format_req   = 1'b0;
   logic        autosave_en  = 1'b0;
   logic        osd_status   = 1'b0;
   logic        ram_wr       = 1'b0;
   logic [1:0]  slot         = 2'd0;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack       = 1'b0;
   logic        fmt_we;
   logic [11:0] fmt_addr;
   logic [15:0] fmt_data;
   logic        bk_ena;
   logic        bk_busy;
   logic        bk_loading;
   logic        bk_pending;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   bkram_save_ctrl #(
      .SECTORS   (16),
      .SLOT_W    (2),
      .HDR_WORDS (4),
      .HDR       (64'h8010_8800_4D42_5548)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .downloading  (downloading),
      .img_mounted  (img_mounted),
      .img_readonly (img_readonly),
      .img_size_nz  (img_size_nz),
      .load_req     (load_req),
      .save_req     (save_req),
      .format_req   (format_req),
      .autosave_en  (autosave_en),
      .osd_status   (osd_status),
      .ram_wr       (ram_wr),
      .slot         (slot),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .fmt_we       (fmt_we),
      .fmt_addr     (fmt_addr),
      .fmt_data     (fmt_data),
      .bk_ena       (bk_ena),
      .bk_busy      (bk_busy),
      .bk_loading   (bk_loading),
      .bk_pending   (bk_pending)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the active edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Serve n sector handshakes starting at lba base; exp_rd selects direction.
   task automatic run_sectors(input int n, input logic exp_rd, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         while (!(sd_rd || sd_wr) && w < 20) begin
            tick();
            w++;
         end
         check("strobe_seen", {31'd0, sd_rd | sd_wr}, 32'd1);
         check("sd_lba", sd_lba, base + 32'(i));
         check("sd_rd", {31'd0, sd_rd}, {31'd0, exp_rd});
         check("sd_wr", {31'd0, sd_wr}, {31'd0, ~exp_rd});
         check("bk_loading", {31'd0, bk_loading}, {31'd0, exp_rd});
         check("bk_busy", {31'd0, bk_busy}, 32'd1);
         sd_ack = 1'b1;
         tick();
         tick();
         check("strobe_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
         sd_ack = 1'b0;
         tick();
      end
   endtask

   // Run one format and check every word written.
   task automatic run_format(input logic exp_pending);
      int i;
      logic [15:0] exp_d;
      format_req = 1'b1;
      tick();
      check("fmt_busy", {31'd0, bk_busy}, 32'd1);
      i = 0;
      while (fmt_we && i < 5000) begin
         case (i)
            0:       exp_d = 16'h5548;
            1:       exp_d = 16'h4D42;
            2:       exp_d = 16'h8800;
            3:       exp_d = 16'h8010;
            default: exp_d = 16'h0000;
         endcase
         check("fmt_addr", {20'd0, fmt_addr}, 32'(i));
         check("fmt_data", {16'd0, fmt_data}, {16'd0, exp_d});
         tick();
         i++;
      end
      check("fmt_count", 32'(i), 32'd4096);
      check("fmt_addr_end", {20'd0, fmt_addr}, 32'd0);
      check("fmt_busy_end", {31'd0, bk_busy}, 32'd0);
      check("fmt_pending", {31'd0, bk_pending}, {31'd0, exp_pending});
      format_req = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_outs", {sd_lba, 12'd0} == '0 ? {24'd0, sd_rd, sd_wr, fmt_we, bk_ena,
            bk_busy, bk_loading, bk_pending, 1'b0} : 32'hFFFF_FFFF, 32'd0);
      check("rst_fmt", {4'd0, fmt_addr, fmt_data}, 32'd0);
      reset = 1'b0;
      tick();

      // Mount writable image during download, then load on download end
      downloading = 1'b1;
      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
      check("ena_mount", {31'd0, bk_ena}, 32'd1);
      tick();
      tick();
      check("ena_hold", {31'd0, bk_ena}, 32'd1);
      slot        = 2'd1;
      img_size_nz = 1'b1;
      downloading = 1'b0;
      tick();
      run_sectors(16, 1'b1, 32'd16);
      check("load_done_busy", {31'd0, bk_busy}, 32'd0);
      check("load_done_ld", {31'd0, bk_loading}, 32'd0);
      check("load_done_rd", {31'd0, sd_rd}, 32'd0);

      // Simultaneous save and load: load wins
      slot     = 2'd2;
      save_req = 1'b1;
      load_req = 1'b1;
      tick();
      run_sectors(16, 1'b1, 32'd32);
      check("both_idle_wr", {31'd0, sd_wr}, 32'd0);
      check("both_busy", {31'd0, bk_busy}, 32'd0);
      save_req = 1'b0;
      load_req = 1'b0;
      tick();

      // Autosave on OSD open after a core write
      slot        = 2'd0;
      autosave_en = 1'b1;
      ram_wr      = 1'b1;
      tick();
      ram_wr = 1'b0;
      check("pending_set", {31'd0, bk_pending}, 32'd1);
      check("pending_idle", {31'd0, bk_busy}, 32'd0);
      osd_status = 1'b1;
      tick();
      check("auto_pending_clr", {31'd0, bk_pending}, 32'd0);
      run_sectors(16, 1'b0, 32'd0);
      check("auto_done_busy", {31'd0, bk_busy}, 32'd0);
      osd_status = 1'b0;
      tick();

      // Read-only mount disables saving; load request is ignored
      downloading  = 1'b1;
      img_mounted  = 1'b1;
      img_readonly = 1'b1;
      tick();
      check("ro_ena", {31'd0, bk_ena}, 32'd0);
      img_mounted  = 1'b0;
      img_readonly = 1'b0;
      img_size_nz  = 1'b0;
      downloading  = 1'b0;
      tick();
      load_req = 1'b1;
      tick();
      tick();
      tick();
      check("ro_no_strobe", {30'd0, sd_rd, sd_wr}, 32'd0);
      check("ro_busy", {31'd0, bk_busy}, 32'd0);
      load_req = 1'b0;
      tick();

      // Format without save enable: no pending afterwards
      run_format(1'b0);

      // Re-enable (no image size so no load), format sets pending
      downloading = 1'b1;
      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
      downloading = 1'b0;
      tick();
      tick();
      check("reena", {31'd0, bk_ena}, 32'd1);
      check("reena_busy", {31'd0, bk_busy}, 32'd0);
      run_format(1'b1);

      // Reset mid-transfer in sector 5
      slot     = 2'd3;
      load_req = 1'b1;
      tick();
      run_sectors(5, 1'b1, 32'd48);
      check("s5_lba", sd_lba, 32'd53);
      sd_ack = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_strobes", {27'd0, sd_rd, sd_wr, fmt_we, bk_busy, bk_loading}, 32'd0);
      check("async_lba", sd_lba, 32'd0);
      check("async_bk", {30'd0, bk_ena, bk_pending}, 32'd0);
      sd_ack   = 1'b0;
      load_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      // Format start is only possible from IDLE
      format_req = 1'b1;
      tick();
      check("post_rst_fmt", {30'd0, fmt_we, bk_busy}, 32'd3);
      check("post_rst_addr", {20'd0, fmt_addr}, 32'd0);
      reset = 1'b1;
      #1;
      check("fmt_abort", {31'd0, fmt_we}, 32'd0);
      format_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bkram_save_ctrl.md
BKRAM_SAVE_CTRL -- requirements
Module: bkram_save_ctrl

Parameters (one per line: name, default, meaning)
REQ-001 SHALL provide SECTORS, 16, number of 512-byte sectors per save slot (power of two, 1..256).
REQ-002 SHALL provide SLOT_W, 2, width of the slot select; there are 2^SLOT_W slots.
REQ-003 SHALL provide HDR_WORDS, 4, number of header words written by format (1..4).
REQ-004 SHALL provide HDR, 64'h8010_8800_4D42_5548, the format header; word k is HDR[16k+15:16k].

Interface (name  direction  width  meaning)
REQ-005 SHALL have clk_sys  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have downloading  in  1  cart download active.
REQ-007 SHALL have img_mounted, img_readonly, img_size_nz  in  1 each  save-image mount pulse, read-only flag, and image-size-nonzero flag.
REQ-008 SHALL have load_req, save_req, format_req, autosave_en, osd_status, ram_wr  in  1 each  OSD request levels, autosave enable, OSD-open flag, and core backup-RAM write strobe.
REQ-009 SHALL have slot  in  SLOT_W  save slot selected.
REQ-010 SHALL have sd_lba  out  32, sd_rd  out  1, sd_wr  out  1, and sd_ack  in  1 for the sector handshake.
REQ-011 SHALL have fmt_we  out  1, fmt_addr  out  log2(SECTORS*256), and fmt_data  out  16 as the backup-RAM format write port.
REQ-012 SHALL have bk_ena, bk_busy, bk_loading, bk_pending  out  1 each  save enabled, transfer/format busy, core hold-in-reset, and unsaved changes.

Function
REQ-013 SHALL clear bk_ena on the rising edge of downloading and set it on any cycle with downloading & img_mounted & ~img_readonly; set wins in the same cycle.
REQ-014 SHALL detect rising edges of load_req, save_req, format_req, the falling edge of downloading, and the rising edge of (bk_pending & osd_status & autosave_en), using history registers reset to 0.
REQ-015 SHALL implement the FSM IDLE, REQ, XFER, FMT; events arriving outside IDLE are dropped, not queued.
REQ-016 SHALL start a load in IDLE on a load_req edge & bk_ena, or on a downloading fall & img_size_nz & bk_ena.
REQ-017 SHALL start a save in IDLE on a save_req edge or autosave edge, & bk_ena; if load and save start in the same cycle, load wins.
REQ-018 SHALL, on transfer start: latch slot, set sector=0, sd_lba=slot*SECTORS, bk_busy=1, bk_loading=load, raise sd_rd (load) or sd_wr (save), and go to REQ.
REQ-019 SHALL, in REQ on the sd_ack rising edge: drop sd_rd/sd_wr on the next cycle and go to XFER.
REQ-020 SHALL, in XFER on the sd_ack falling edge: if sector==SECTORS-1, go to IDLE with bk_busy=0 and bk_loading=0; otherwise increment sector and sd_lba, re-raise the same strobe, and go to REQ.
REQ-021 SHALL keep sd_lba slot-relative with no wrap into the next slot; the last slot ends at 2^SLOT_W*SECTORS-1.
REQ-022 SHALL start FMT in IDLE on a format_req edge without requiring bk_ena: bk_busy=1, fmt_addr=0.
REQ-023 SHALL, in FMT, hold fmt_we=1 and increment fmt_addr every cycle, with fmt_data = HDR word fmt_addr for fmt_addr<HDR_WORDS and 0 otherwise.
REQ-024 SHALL, in FMT after the write at address SECTORS*256-1, go to IDLE with fmt_we=0, fmt_addr=0, and bk_busy=0 (SECTORS*256 writes total).
REQ-025 SHALL set bk_pending on ram_wr & bk_ena & ~osd_status, or on FMT completion & bk_ena.
REQ-026 SHALL clear bk_pending on any transfer start; a set condition in the same cycle wins.
REQ-027 SHALL leave sd_rd and sd_wr never both high, and fmt_we never high outside FMT.

Reset
REQ-028 SHALL, while reset is high, asynchronously force state=IDLE, sd_lba=0, sd_rd=sd_wr=0, fmt_we=0, fmt_addr=0, fmt_data=0, all bk_* outputs=0, sector=0, and history registers=0.
REQ-029 SHALL abandon a transfer or format when reset is asserted mid-operation; after release, a request level still high counts as a rising edge.

Verification
REQ-030 Download with img_mounted, then downloading falls with img_size_nz=1, SECTORS=16, slot=1 -> 16 sd_rd handshakes with lba 16..31, bk_loading high throughout, then bk_busy=0.
REQ-031 save_req and load_req rise in the same idle cycle -> load executes (sd_rd) and no sd_wr occurs.
REQ-032 ram_wr with OSD closed, autosave_en=1, then osd_status rises -> bk_pending=1 then a save (sd_wr) starts and bk_pending=0.
REQ-033 format_req edge -> 4096 fmt_we cycles with data 5548,4D42,8800,8010 then 0; bk_pending=1 if bk_ena.
REQ-034 img_readonly=1 mount, then load_req -> bk_ena=0 and no sd strobe.
REQ-035 reset asserted in XFER of sector 5 -> all outputs return to 0 immediately, FSM in IDLE after release.
